// File: rtl/wallace_pipe.sv
// wallace_pipe
//   Pipelined Wallace-tree reducer for the radix-4 Booth multiplier datapath.
//   Takes SIZE/2 Booth partial-product rows plus one correction vector and
//   compresses them with 3:2 carry-save levels down to a sum/carry pair,
//   optionally resolved to one product by a final carry-propagate adder.
//   Everything is modulo 2^(2*SIZE).
//
// Parameters
//   SIZE       multiplicand width (even, >= 4); NROW = SIZE/2 rows of SIZE+1 bits
//   PIPE       1: register after every CSA level; 0: one register after the tree
//   FINAL_ADD  1: extra stage adds sum+carry, out_carry forced to 0
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input handshake for pp/cor
//   pp                   row i = pp[i*(SIZE+1) +: SIZE+1], weight 2^(2i)
//   cor                  Booth sign/negate correction vector, weight 2^0
//   flush                synchronous drop of everything in flight
//   out_valid/out_ready  output handshake
//   out_sum, out_carry   result pair (carry already at its true weight)
//   busy                 any stage holds valid data
module wallace_pipe #(
  parameter int SIZE      = 8,
  parameter int PIPE      = 1,
  parameter int FINAL_ADD = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [(SIZE/2)*(SIZE+1)-1:0]    pp,
  input  logic [2*SIZE-1:0]               cor,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*SIZE-1:0]               out_sum,
  output logic [2*SIZE-1:0]               out_carry,
  output logic                            busy
);

  localparam int NROW = SIZE / 2;
  localparam int PPW  = SIZE + 1;
  localparam int W    = 2 * SIZE;
  localparam int NOPS = NROW + 1;

  // Operand count entering level lvl of the tree.
  function automatic int ops_at(input int lvl);
    int n;
    n = NOPS;
    for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  // Number of 3:2 levels needed to reach a pair.
  function automatic int num_levels(input int n0);
    int n;
    int c;
    n = n0;
    c = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      c++;
    end
    return c;
  endfunction

  localparam int LEVELS = num_levels(NOPS);
  localparam int TSTG   = (PIPE != 0) ? LEVELS : 1;
  localparam int STG    = TSTG + ((FINAL_ADD != 0) ? 1 : 0);

  // ---------------------------------------------------------------------
  // Handshake / valid pipeline
  //   vld_pipe[0] is the accept strobe, vld_pipe[k] the valid of stage k.
  //   One global enable: the whole pipe shifts or the whole pipe holds.
  // ---------------------------------------------------------------------
  logic           w_adv;
  logic           w_acc;
  logic [STG:1]   r_vld;
  logic [STG:0]   vld_pipe;

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv && !flush;
  assign w_acc     = in_valid && in_ready;
  assign vld_pipe  = {r_vld, w_acc};
  assign out_valid = r_vld[STG];
  assign busy      = |r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_vld <= '0;
    else if (flush)  r_vld <= '0;
    else if (w_adv)  r_vld <= vld_pipe[STG-1:0];
  end

  // ---------------------------------------------------------------------
  // Level-0 operands: rows zero-extended and placed at weight 2^(2i);
  // the correction vector rides as the last operand.
  // ---------------------------------------------------------------------
  logic [NOPS-1:0][W-1:0] w_ops0;

  for (genvar i = 0; i < NROW; i++) begin : g_row
    assign w_ops0[i] = {{(W-PPW){1'b0}}, pp[i*PPW +: PPW]} << (2*i);
  end
  assign w_ops0[NROW] = cor;

  // ---------------------------------------------------------------------
  // CSA levels. Each group of three operands becomes a sum vector and a
  // carry vector shifted up one place (top carry discarded, modulo 2^W).
  // A column with only two live bits degenerates into a half adder since
  // the third operand bit is zero; a lone bit passes straight through.
  // ---------------------------------------------------------------------
  logic [W-1:0] w_tree_s;
  logic [W-1:0] w_tree_c;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = ops_at(l);
    localparam int NO = ops_at(l + 1);
    localparam int NG = NI / 3;
    // valid bit that qualifies this level's input register load
    localparam int VI = (PIPE != 0) ? l + 1 : 1;

    logic [NI-1:0][W-1:0] w_i;
    logic [NO-1:0][W-1:0] w_c;
    logic [NO-1:0][W-1:0] w_o;

    if (l == 0) begin : g_src0
      assign w_i = w_ops0;
    end else begin : g_srcn
      assign w_i = g_lvl[l-1].w_o;
    end

    for (genvar g = 0; g < NG; g++) begin : g_fa
      logic [W-2:0] w_maj;
      assign w_maj = (w_i[3*g][W-2:0]   & w_i[3*g+1][W-2:0]) |
                     (w_i[3*g][W-2:0]   & w_i[3*g+2][W-2:0]) |
                     (w_i[3*g+1][W-2:0] & w_i[3*g+2][W-2:0]);
      assign w_c[2*g]   = w_i[3*g] ^ w_i[3*g+1] ^ w_i[3*g+2];
      assign w_c[2*g+1] = {w_maj, 1'b0};
    end

    // leftover operands (NI % 3) pass to the next level unchanged
    for (genvar k = 0; k < NI % 3; k++) begin : g_pass
      assign w_c[2*NG+k] = w_i[3*NG+k];
    end

    if (PIPE != 0 || l == LEVELS - 1) begin : g_reg
      logic [NO-1:0][W-1:0] r_q;
      // loads only when a valid op moves in; bubbles leave data untouched
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_q <= '0;
        else if (w_adv && vld_pipe[VI-1]) r_q <= w_c;
      end
      assign w_o = r_q;
    end else begin : g_cmb
      assign w_o = w_c;
    end

    if (l == LEVELS - 1) begin : g_last
      assign w_tree_s = w_o[0];
      assign w_tree_c = w_o[1];
    end
  end

  // ---------------------------------------------------------------------
  // Optional carry-propagate stage
  // ---------------------------------------------------------------------
  if (FINAL_ADD != 0) begin : g_cpa
    logic [W-1:0] r_prod;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_prod <= '0;
      else if (w_adv && vld_pipe[STG-1])   r_prod <= w_tree_s + w_tree_c;
    end
    assign out_sum   = r_prod;
    assign out_carry = '0;
  end else begin : g_nocpa
    assign out_sum   = w_tree_s;
    assign out_carry = w_tree_c;
  end

endmodule
